// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer controller: state encoding and reload mode constants.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_AUTO    = 1'b1;

endpackage

// File: rtl/timer_ctrl_presc_div.sv
// Prescaler for the timer: counts while advanced, ticks when it reaches the limit, then restarts at 0.
module presc_div #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               advance,
  input  logic [PRESC_W-1:0] limit,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  assign tick = (cnt_q == limit);

  // Holding is the default, so a paused timer resumes from where it stopped.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: drives clear/enable of an external 4-bit counter through IDLE/RUN/PAUSE/DONE,
// with a prescaled count rate and one-shot or auto-reload operation.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               clr,
  input  logic               mode,
  input  logic [3:0]         period,
  input  logic [PRESC_W-1:0] presc,
  input  logic [3:0]         cnt_val,
  output logic               cnt_rst,
  output logic               cnt_ce,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [3:0]         period_q, period_d;
  logic               mode_q, mode_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               done_q, done_d;

  logic presc_clear;
  logic presc_advance;
  logic tick;
  logic terminal;
  logic cnt_rst_c;
  logic cnt_ce_c;

  presc_div #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .rst     (rst),
    .clear   (presc_clear),
    .advance (presc_advance),
    .limit   (presc_q),
    .tick    (tick)
  );

  assign terminal = (state_q == ST_RUN) && (cnt_val == period_q);

  // Terminal count is treated as completion and wins over a stop in the same cycle.
  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    mode_d        = mode_q;
    presc_d       = presc_q;
    done_d        = 1'b0;
    presc_clear   = 1'b0;
    presc_advance = 1'b0;
    cnt_rst_c     = 1'b0;
    cnt_ce_c      = 1'b0;
    if (clr) begin
      cnt_rst_c   = 1'b1;
      presc_clear = 1'b1;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            period_d    = period;
            mode_d      = mode;
            presc_d     = presc;
            cnt_rst_c   = 1'b1;
            presc_clear = 1'b1;
            state_d     = ST_RUN;
          end
        end
        ST_RUN: begin
          if (terminal) begin
            done_d      = 1'b1;
            presc_clear = 1'b1;
            if (mode_q == MODE_AUTO) cnt_rst_c = 1'b1;
            else                     state_d   = ST_DONE;
          end else begin
            presc_advance = 1'b1;
            cnt_ce_c      = tick;
            if (stop) state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      mode_q   <= MODE_ONESHOT;
      presc_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
    end
  end

  // Reset is synchronous, so outputs are masked directly while it is held.
  assign cnt_rst = rst | cnt_rst_c;
  assign cnt_ce  = ~rst & cnt_ce_c;
  assign busy    = ~rst & ((state_q == ST_RUN) || (state_q == ST_PAUSE));
  assign done    = ~rst & done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: a cycle-accurate scoreboard of expected {cnt_ce, cnt_rst, done, busy},
// with a behavioural 4-bit counter closing the loop on cnt_val.
module tb_timer_ctrl;

  localparam int PRESC_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic               clr;
  logic               mode;
  logic [3:0]         period;
  logic [PRESC_W-1:0] presc;
  logic [3:0]         cnt_val = 4'd0;
  logic               cnt_rst;
  logic               cnt_ce;
  logic               busy;
  logic               done;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] sb_q[$];

  timer_ctrl #(.PRESC_W(PRESC_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .clr     (clr),
    .mode    (mode),
    .period  (period),
    .presc   (presc),
    .cnt_val (cnt_val),
    .cnt_rst (cnt_rst),
    .cnt_ce  (cnt_ce),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // The controlled counter: synchronous clear, +1 per enable, wraps at 15.
  always @(posedge clk) begin
    if (cnt_rst)     cnt_val <= 4'd0;
    else if (cnt_ce) cnt_val <= cnt_val + 4'd1;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, want %b", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs and records the outputs expected for that cycle.
  task automatic applyStimulus(input logic st, input logic sp, input logic cl, input logic rs,
                               input logic md, input logic [3:0] per, input logic [PRESC_W-1:0] pr,
                               input logic e_ce, input logic e_rst, input logic e_done, input logic e_busy);
    start  = st;
    stop   = sp;
    clr    = cl;
    rst    = rs;
    mode   = md;
    period = per;
    presc  = pr;
    sb_q.push_back({e_ce, e_rst, e_done, e_busy});
  endtask

  task automatic stepCycle(input string tag);
    logic [3:0] exp_v;
    @(negedge clk);
    if (sb_q.size() == 0) exp_v = 4'bxxxx;
    else                  exp_v = sb_q.pop_front();
    checkOutput(tag, {4'd0, cnt_ce, cnt_rst, done, busy}, {4'd0, exp_v});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0;
    mode = 1'b0; period = 4'd0; presc = '0;
    @(posedge clk);
    #1;

    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, c < 2, 1'b0, 4'd0, 8'd0, 1'b0, c < 2, 1'b0, 1'b0);
      stepCycle($sformatf("reset%0d", c));
    end

    // One-shot, presc=2, period=3; period/presc/mode are scrambled after the load.
    for (int c = 0; c < 14; c++) begin
      applyStimulus(c == 0, 1'b0, 1'b0, 1'b0,
                    (c == 0) ? 1'b0 : 1'b1, (c == 0) ? 4'd3 : 4'd9, (c == 0) ? 8'd2 : 8'd0,
                    (c == 3) || (c == 6) || (c == 9), c == 0, c == 11, (c >= 1) && (c <= 10));
      if (c == 10) begin
        @(negedge clk);
        checkOutput("oneshot_cntval", {4'd0, cnt_val}, 8'd3);
        @(posedge clk);
        #1;
        sb_q.delete(0);
      end else begin
        stepCycle($sformatf("oneshot%0d", c));
      end
    end

    // Auto-reload, presc=0, period=2, then clr together with start while running.
    for (int c = 0; c < 14; c++) begin
      applyStimulus((c == 0) || (c == 5) || (c == 11), 1'b0, c == 11, 1'b0,
                    1'b1, 4'd2, 8'd0,
                    (c >= 1) && (c <= 10) && (c % 3 != 0),
                    ((c <= 9) && (c % 3 == 0)) || (c == 11),
                    (c >= 4) && (c <= 10) && (c % 3 == 1),
                    (c >= 1) && (c <= 11));
      stepCycle($sformatf("auto%0d", c));
    end

    // One-shot paused at cycle 4 and resumed at cycle 10; stray start in RUN and stop in PAUSE.
    for (int c = 0; c < 20; c++) begin
      applyStimulus((c == 0) || (c == 2) || (c == 10), (c == 4) || (c == 7), 1'b0, 1'b0,
                    1'b0, 4'd3, 8'd2,
                    (c == 3) || (c == 12) || (c == 15), c == 0, c == 17, (c >= 1) && (c <= 16));
      stepCycle($sformatf("pause%0d", c));
    end

    // Zero period: terminal on the first RUN cycle, no enables, ends in DONE.
    for (int c = 0; c < 5; c++) begin
      applyStimulus(c == 0, c == 3, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0,
                    1'b0, c == 0, c == 2, c == 1);
      stepCycle($sformatf("zero%0d", c));
    end

    // Reset mid-RUN, then a fresh start behaves as from power-up.
    for (int c = 0; c < 12; c++) begin
      applyStimulus((c == 0) || (c == 5) || (c == 7), c == 6, 1'b0, (c == 4) || (c == 5),
                    1'b0, 4'd3, 8'd2,
                    (c == 3) || (c == 10),
                    (c == 0) || (c == 4) || (c == 5) || (c == 7),
                    1'b0,
                    ((c >= 1) && (c <= 3)) || (c >= 8));
      stepCycle($sformatf("midrst%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
